// File: rtl/aeolus_execute_unit.sv
// Purpose: Aeolus execute stage (operand select, conditional-add resolution, ALU, 8-bit accumulator).
// Latency: alu_out/overflow/add_en are combinational; acc_out updates one clock after the strobe is sampled.
// Backpressure: none; a strobe is accepted every cycle. Optional AEOLUS_STICKY_OVF_EN builds the sticky overflow flag.
module aeolus_execute_unit #(
  parameter int IN_WIDTH  = 4,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ADD,
  input  logic                 SUB,
  input  logic                 AND,
  input  logic                 OR,
  input  logic                 XOR,
  input  logic                 INV,
  input  logic                 CLR,
  input  logic                 SNZA,
  input  logic                 SNZS,
  input  logic                 SF,
  input  logic [IN_WIDTH-1:0]  a_in,
  input  logic [IN_WIDTH-1:0]  b_in,
  input  logic [OUT_WIDTH-1:0] shift_in,
  output logic [OUT_WIDTH-1:0] acc_out,
  output logic [OUT_WIDTH-1:0] alu_out,
  output logic                 overflow,
  output logic                 add_en,
  output logic                 ovf_sticky
);

  logic [OUT_WIDTH-1:0] a_ext;
  logic [OUT_WIDTH-1:0] b_ext;
  logic [OUT_WIDTH-1:0] in1;
  logic [OUT_WIDTH-1:0] in2;
  logic [OUT_WIDTH:0]   sum_w;
  logic [OUT_WIDTH:0]   diff_w;
  logic                 acc_en;

  // Conditional adds only fire when the shift flag is set.
  assign add_en = ADD | ((SNZA | SNZS) & SF);
  assign acc_en = AND | OR | XOR | INV | add_en | SUB | CLR;

  // Operand select: conditional adds accumulate into ACC, SNZA beats SNZS.
  always_comb begin
    a_ext = '0;
    b_ext = '0;
    a_ext[IN_WIDTH-1:0] = a_in;
    b_ext[IN_WIDTH-1:0] = b_in;
    if (SNZA) begin
      in1 = acc_out;
      in2 = a_ext;
    end else if (SNZS) begin
      in1 = acc_out;
      in2 = shift_in;
    end else begin
      in1 = a_ext;
      in2 = b_ext;
    end
  end

  // One extra bit on each side captures carry-out and borrow.
  assign sum_w  = {1'b0, in1} + {1'b0, in2};
  assign diff_w = {1'b0, in1} - {1'b0, in2};

  // ALU with fixed priority so illegal multi-strobe cycles still resolve deterministically.
  always_comb begin
    alu_out  = '0;
    overflow = 1'b0;
    if (CLR) begin
      alu_out = '0;
    end else if (add_en) begin
      alu_out  = sum_w[OUT_WIDTH-1:0];
      overflow = sum_w[OUT_WIDTH];
    end else if (SUB) begin
      alu_out  = diff_w[OUT_WIDTH-1:0];
      overflow = diff_w[OUT_WIDTH];
    end else if (AND) begin
      alu_out = in1 & in2;
    end else if (OR) begin
      alu_out = in1 | in2;
    end else if (XOR) begin
      alu_out = in1 ^ in2;
    end else if (INV) begin
      alu_out = ~in1;
    end
  end

  // Accumulator: reset > CLR > load > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_out <= '0;
    end else if (CLR) begin
      acc_out <= '0;
    end else if (acc_en) begin
      acc_out <= alu_out;
    end
  end

`ifdef AEOLUS_STICKY_OVF_EN
  // Sticky overflow: any loaded carry/borrow sets it until reset or CLR.
  always_ff @(posedge clk) begin
    if (reset || CLR) begin
      ovf_sticky <= 1'b0;
    end else if (acc_en && overflow) begin
      ovf_sticky <= 1'b1;
    end
  end
`else
  assign ovf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_aeolus_execute_unit.sv
// Purpose: directed-vector bench for aeolus_execute_unit with a behavioural model and per-cycle compare.
// Latency: model accumulator advances on each rising edge; outputs are compared on the falling edge.
// Backpressure: none; one stimulus vector per clock.
module tb_aeolus_execute_unit;

  localparam int O_ADD  = 1;
  localparam int O_SUB  = 2;
  localparam int O_AND  = 4;
  localparam int O_OR   = 8;
  localparam int O_XOR  = 16;
  localparam int O_INV  = 32;
  localparam int O_CLR  = 64;
  localparam int O_SNZA = 128;
  localparam int O_SNZS = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       op_add = 0, op_sub = 0, op_and = 0, op_or = 0, op_xor = 0;
  logic       op_inv = 0, op_clr = 0, op_snza = 0, op_snzs = 0, sf = 0;
  logic [3:0] a_in = 0, b_in = 0;
  logic [7:0] shift_in = 0;
  logic [7:0] acc_out, alu_out;
  logic       overflow, add_en, ovf_sticky;

  int  n_vec  = 0;
  int  n_miss = 0;
  bit  chk_en = 0;
  int  m_acc  = 0;
  bit  m_st   = 0;

  aeolus_execute_unit #(.IN_WIDTH(4), .OUT_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .ADD(op_add), .SUB(op_sub), .AND(op_and), .OR(op_or), .XOR(op_xor),
    .INV(op_inv), .CLR(op_clr), .SNZA(op_snza), .SNZS(op_snzs), .SF(sf),
    .a_in(a_in), .b_in(b_in), .shift_in(shift_in),
    .acc_out(acc_out), .alu_out(alu_out), .overflow(overflow),
    .add_en(add_en), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected combinational results straight from the instruction rules, using integer arithmetic.
  function automatic void model(output int alu, output bit ovf, output bit add);
    int in1, in2;
    add = op_add || ((op_snza || op_snzs) && sf);
    if (op_snza)      begin in1 = m_acc; in2 = int'(a_in);     end
    else if (op_snzs) begin in1 = m_acc; in2 = int'(shift_in); end
    else              begin in1 = int'(a_in); in2 = int'(b_in); end
    ovf = 0;
    if (op_clr)       alu = 0;
    else if (add)     begin alu = in1 + in2; ovf = (alu > 255); end
    else if (op_sub)  begin alu = in1 - in2; ovf = (in1 < in2); end
    else if (op_and)  alu = in1 & in2;
    else if (op_or)   alu = in1 | in2;
    else if (op_xor)  alu = in1 ^ in2;
    else if (op_inv)  alu = 255 - in1;
    else              alu = 0;
    alu = alu & 255;
  endfunction

  // Model state update at the clock edge.
  always @(posedge clk) begin
    int e_alu; bit e_ovf, e_add, any;
    model(e_alu, e_ovf, e_add);
    any = op_and || op_or || op_xor || op_inv || e_add || op_sub || op_clr;
    if (reset || op_clr) begin
      m_acc = 0;
      m_st  = 0;
    end else if (any) begin
      m_acc = e_alu;
`ifdef AEOLUS_STICKY_OVF_EN
      if (e_ovf) m_st = 1;
`endif
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    int e_alu; bit e_ovf, e_add;
    if (chk_en) begin
      model(e_alu, e_ovf, e_add);
      chk("alu_out", int'(alu_out), e_alu);
      chk("overflow", int'(overflow), int'(e_ovf));
      chk("add_en", int'(add_en), int'(e_add));
      chk("acc_out", int'(acc_out), m_acc);
      chk("ovf_sticky", int'(ovf_sticky), int'(m_st));
    end
  end

  // Apply one vector after the edge, then return just past the falling edge.
  task automatic step(input int op, input int a, input int b, input int sh, input bit f);
    @(posedge clk);
    #1;
    op_add  = (op & O_ADD)  != 0;
    op_sub  = (op & O_SUB)  != 0;
    op_and  = (op & O_AND)  != 0;
    op_or   = (op & O_OR)   != 0;
    op_xor  = (op & O_XOR)  != 0;
    op_inv  = (op & O_INV)  != 0;
    op_clr  = (op & O_CLR)  != 0;
    op_snza = (op & O_SNZA) != 0;
    op_snzs = (op & O_SNZS) != 0;
    a_in = 4'(a); b_in = 4'(b); shift_in = 8'(sh); sf = f;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    chk_en = 1;
    @(negedge clk); #1;
    chk("lit_reset_acc", int'(acc_out), 8'h00);
    chk("lit_reset_sticky", int'(ovf_sticky), 0);

    // Add and reset-over-ADD
    step(O_ADD, 4'hF, 4'h1, 0, 0);
    chk("lit_add_alu", int'(alu_out), 8'h10);
    chk("lit_add_ovf", int'(overflow), 0);
    step(0, 0, 0, 0, 0);
    chk("lit_add_acc", int'(acc_out), 8'h10);
    step(O_ADD, 4'hF, 4'h1, 0, 0);
    reset = 1;
    step(0, 0, 0, 0, 0);
    chk("lit_reset_over_add", int'(acc_out), 8'h00);
    chk("lit_reset_sticky2", int'(ovf_sticky), 0);
    reset = 0;

    // Subtract and logic ops
    step(O_SUB, 4'h1, 4'h2, 0, 0);
    chk("lit_sub_alu", int'(alu_out), 8'hFF);
    chk("lit_sub_ovf", int'(overflow), 1);
    step(O_AND, 4'hC, 4'hA, 0, 0);
    chk("lit_and_alu", int'(alu_out), 8'h08);
    chk("lit_sub_acc", int'(acc_out), 8'hFF);
    step(O_XOR, 4'hC, 4'hA, 0, 0);
    chk("lit_xor_alu", int'(alu_out), 8'h06);
    step(O_OR, 4'hC, 4'hA, 0, 0);
    chk("lit_or_alu", int'(alu_out), 8'h0E);
    step(O_INV, 4'h3, 0, 0, 0);
    chk("lit_inv_alu", int'(alu_out), 8'hFC);
    step(O_AND | O_XOR, 4'hC, 4'hA, 0, 0);
    chk("lit_multi_strobe", int'(alu_out), 8'h08);

    // SNZS conditional add
    step(O_CLR, 0, 0, 0, 0);
    step(O_ADD, 4'h5, 4'h0, 0, 0);
    step(O_SNZS, 0, 0, 8'h0C, 1);
    chk("lit_snzs_acc0", int'(acc_out), 8'h05);
    chk("lit_snzs_add_en", int'(add_en), 1);
    step(O_SNZS, 0, 0, 8'h0C, 0);
    chk("lit_snzs_acc1", int'(acc_out), 8'h11);
    chk("lit_snzs_noadd", int'(add_en), 0);
    step(0, 0, 0, 0, 0);
    chk("lit_snzs_hold", int'(acc_out), 8'h11);

    // SNZA with wrap
    step(O_CLR, 0, 0, 0, 0);
    step(O_SUB, 4'h0, 4'h2, 0, 0);
    step(O_SNZA, 4'h3, 0, 0, 1);
    chk("lit_snza_acc0", int'(acc_out), 8'hFE);
    chk("lit_snza_alu", int'(alu_out), 8'h01);
    chk("lit_snza_ovf", int'(overflow), 1);
    step(0, 0, 0, 0, 0);
    chk("lit_snza_acc1", int'(acc_out), 8'h01);
`ifdef AEOLUS_STICKY_OVF_EN
    chk("lit_snza_sticky", int'(ovf_sticky), 1);
`else
    chk("lit_snza_sticky", int'(ovf_sticky), 0);
`endif

    // CLR from 0x37, and CLR together with ADD
    step(O_CLR, 0, 0, 0, 0);
    step(O_SNZS, 0, 0, 8'h37, 1);
    step(O_CLR, 0, 0, 0, 0);
    chk("lit_clr_acc0", int'(acc_out), 8'h37);
    step(0, 0, 0, 0, 0);
    chk("lit_clr_acc1", int'(acc_out), 8'h00);
    chk("lit_clr_sticky", int'(ovf_sticky), 0);
    step(O_ADD, 4'hF, 4'h1, 0, 0);
    step(O_CLR | O_ADD, 4'hF, 4'h1, 0, 0);
    chk("lit_clradd_alu", int'(alu_out), 8'h00);
    step(0, 0, 0, 0, 0);
    chk("lit_clradd_acc", int'(acc_out), 8'h00);

    // Idle hold
    step(O_ADD, 4'h7, 4'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      chk("lit_idle_acc", int'(acc_out), 8'h07);
      chk("lit_idle_alu", int'(alu_out), 8'h00);
    end

    // Back-to-back SNZA accumulation: 7 + 2 + 2 + 2
    for (int i = 0; i < 3; i++) step(O_SNZA, 4'h2, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("lit_b2b_acc", int'(acc_out), 8'h0D);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
